tx_arbiter: RTL



---
 rtl/tx_arbiter_pkg.sv | 37 +++
 rtl/tx_arbiter_if.sv | 54 +++++
 rtl/tx_arbiter_owner_fifo.sv | 80 ++++++++
 rtl/tx_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tx_arbiter_pkg
// Shared definitions for the TX channel arbiter:
//   - TX_CMD_BITS       : width of a serial TX command word
//   - TX_HEADER_*       : command header encodings (top nibble of a command)
//   - arb_state_e       : arbiter FSM states (ARB_IDLE / ARB_ARMED / ARB_BUSY)
//   - owner_e           : reply owner encoding (OWNER_PF = 0, OWNER_SCH = 1)
//   - make_cmd()        : packs a header and an address into a command word
// -----------------------------------------------------------------------------
package tx_arbiter_pkg;

    localparam int TX_CMD_BITS = 16;

    localparam logic [3:0] TX_HEADER_READ_16    = 4'h1;
    localparam logic [3:0] TX_HEADER_READ_32    = 4'h2;
    localparam logic [3:0] TX_HEADER_WRITE_16   = 4'h3;
    localparam logic [3:0] TX_HEADER_WRITE_32   = 4'h4;
    localparam logic [3:0] TX_HEADER_PC_WR_PREF = 4'h5;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ARMED = 2'd1,
        ARB_BUSY  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_PF  = 1'b0,
        OWNER_SCH = 1'b1
    } owner_e;

    // Command word layout: {header[3:0], address[11:0]}
    function automatic logic [TX_CMD_BITS-1:0] make_cmd(input logic [3:0]  hdr,
                                                        input logic [11:0] addr);
        return {hdr, addr};
    endfunction

endpackage

// File: rtl/tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// tx_arbiter_if
// Bundles the requester, serializer and RX-side handshake signals of the TX
// arbiter.
//   modport master : the arbiter itself (consumes requests / serializer status,
//                    drives started pulses, presented command and reply routing)
//   modport slave  : the surrounding logic (prefetcher, scheduler, serializer,
//                    RX deframer)
// Signals:
//   pf_cmd_valid, pf_cmd                     prefetcher read request
//   sch_cmd_valid, sch_cmd, sch_reply_wanted scheduler request
//   sch_reserve                              scheduler blocks prefetch starts
//   pf_started, sch_started                  one-cycle acceptance pulses
//   tx_command_valid, tx_command             command presented to serializer
//   tx_command_started, tx_done              serializer status
//   rx_started, rx_done                      RX reply progress
//   rx_for_sch                               reply owner (1 = scheduler)
//   reply_err                                sticky orphan-reply flag
// -----------------------------------------------------------------------------
interface tx_arbiter_if;
    import tx_arbiter_pkg::*;

    logic                   pf_cmd_valid;
    logic [TX_CMD_BITS-1:0] pf_cmd;
    logic                   pf_started;
    logic                   sch_cmd_valid;
    logic [TX_CMD_BITS-1:0] sch_cmd;
    logic                   sch_reply_wanted;
    logic                   sch_reserve;
    logic                   sch_started;
    logic                   tx_command_valid;
    logic [TX_CMD_BITS-1:0] tx_command;
    logic                   tx_command_started;
    logic                   tx_done;
    logic                   rx_started;
    logic                   rx_done;
    logic                   rx_for_sch;
    logic                   reply_err;

    modport master (
        input  pf_cmd_valid, pf_cmd, sch_cmd_valid, sch_cmd, sch_reply_wanted,
               sch_reserve, tx_command_started, tx_done, rx_started, rx_done,
        output pf_started, sch_started, tx_command_valid, tx_command,
               rx_for_sch, reply_err
    );

    modport slave (
        output pf_cmd_valid, pf_cmd, sch_cmd_valid, sch_cmd, sch_reply_wanted,
               sch_reserve, tx_command_started, tx_done, rx_started, rx_done,
        input  pf_started, sch_started, tx_command_valid, tx_command,
               rx_for_sch, reply_err
    );

endinterface

// File: rtl/tx_arbiter_owner_fifo.sv
// -----------------------------------------------------------------------------
// tx_arbiter_owner_fifo
// Remembers, in issue order, which requester owns each outstanding
// reply-expecting read. 1-bit entries (1 = scheduler), MAX_OUT deep.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   push_i      append din_i (ignored when full unless a pop happens too)
//   pop_i       drop the head entry (ignored when empty)
//   din_i       owner bit to append
//   head_o      owner of the oldest entry, 0 when empty
//   empty_o     no outstanding entries
//   full_o      MAX_OUT entries outstanding
// -----------------------------------------------------------------------------
module tx_arbiter_owner_fifo #(
    parameter int MAX_OUT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  logic pop_i,
    input  logic din_i,
    output logic head_o,
    output logic empty_o,
    output logic full_o
);
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUT - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUT);

    logic [MAX_OUT-1:0] mem_q;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push_s, do_pop_s;

    assign empty_o = (count_q == CNT_W'(0));
    assign full_o  = (count_q == FULL_CNT);
    assign head_o  = empty_o ? 1'b0 : mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; a push into a full FIFO is only
    // legal when the head leaves in the same cycle.
    always_comb begin
        do_pop_s  = pop_i & ~empty_o;
        do_push_s = push_i & (~full_o | do_pop_s);
        if (do_push_s) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? PTR_W'(0) : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? PTR_W'(0) : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= din_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// -----------------------------------------------------------------------------
// tx_arbiter
// Shares the serial TX command channel between the instruction prefetcher and
// the scheduler. A grant is held from arbitration until the serializer reports
// tx_done; owners of reply-expecting reads are queued so that RX replies are
// routed back to the requester that issued them.
// Ports:
//   clk    clock
//   reset  asynchronous, active-high reset
//   bus    tx_arbiter_if.master (requests, serializer and RX handshakes)
// Parameters:
//   MAX_OUT       maximum outstanding reply-expecting reads (power of 2, >= 1)
//   STARVE_LIMIT  scheduler grants in a row before the prefetcher is forced
// Build option:
//   TX_ARB_FAIRNESS_EN  when defined, a starvation counter lets the prefetcher
//                       win after STARVE_LIMIT priority-only losses; otherwise
//                       the scheduler has strict priority.
// -----------------------------------------------------------------------------
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int MAX_OUT      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    tx_arbiter_if.master bus
);
    arb_state_e             state_q;
    owner_e                 owner_q;
    logic [TX_CMD_BITS-1:0] cmd_q;
    logic                   reply_q;
    logic                   tx_valid_q;
    logic                   reply_err_q;

    logic fifo_full_s, fifo_empty_s, fifo_head_s;
    logic sch_elig_s, pf_elig_s;
    logic grant_sch_s, grant_pf_s;
    logic accept_s, push_s;

`ifdef TX_ARB_FAIRNESS_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_q;
    logic                starve_hit_s;

    assign starve_hit_s = (starve_q == STARVE_W'(STARVE_LIMIT));
`else
    // The limit only has meaning when the fairness counter is built.
    logic starve_limit_unused_s;
    assign starve_limit_unused_s = (STARVE_LIMIT > 0);
`endif

    // Eligibility and arbitration; decisions are only taken in ARB_IDLE.
    always_comb begin
        sch_elig_s = bus.sch_cmd_valid & ~(bus.sch_reply_wanted & fifo_full_s);
        pf_elig_s  = bus.pf_cmd_valid & ~bus.sch_reserve & ~fifo_full_s;
`ifdef TX_ARB_FAIRNESS_EN
        grant_pf_s = (state_q == ARB_IDLE) & pf_elig_s & (~sch_elig_s | starve_hit_s);
`else
        grant_pf_s = (state_q == ARB_IDLE) & pf_elig_s & ~sch_elig_s;
`endif
        grant_sch_s = (state_q == ARB_IDLE) & sch_elig_s & ~grant_pf_s;
        accept_s    = (state_q == ARB_ARMED) & bus.tx_command_started;
        push_s      = accept_s & reply_q;
    end

    // Arbiter FSM: latch the winner in IDLE, present it in ARMED, wait in BUSY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWNER_PF;
            cmd_q      <= '0;
            reply_q    <= 1'b0;
            tx_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (grant_sch_s) begin
                        owner_q    <= OWNER_SCH;
                        cmd_q      <= bus.sch_cmd;
                        reply_q    <= bus.sch_reply_wanted;
                        tx_valid_q <= 1'b1;
                        state_q    <= ARB_ARMED;
                    end else if (grant_pf_s) begin
                        // Prefetches are always reads, so they always expect a reply.
                        owner_q    <= OWNER_PF;
                        cmd_q      <= bus.pf_cmd;
                        reply_q    <= 1'b1;
                        tx_valid_q <= 1'b1;
                        state_q    <= ARB_ARMED;
                    end
                end
                ARB_ARMED: begin
                    // The latched command is held even if the requester drops valid.
                    if (bus.tx_command_started) begin
                        tx_valid_q <= 1'b0;
                        cmd_q      <= '0;
                        state_q    <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    // Returning to IDLE guarantees one idle cycle between messages.
                    if (bus.tx_done) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: begin
                    state_q    <= ARB_IDLE;
                    tx_valid_q <= 1'b0;
                    cmd_q      <= '0;
                end
            endcase
        end
    end

    // Sticky flag for a reply that arrives with nothing outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reply_err_q <= 1'b0;
        end else if ((bus.rx_started | bus.rx_done) & fifo_empty_s) begin
            reply_err_q <= 1'b1;
        end
    end

`ifdef TX_ARB_FAIRNESS_EN
    // Starvation counter: counts scheduler wins that beat an otherwise-eligible prefetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else if (grant_pf_s) begin
            starve_q <= '0;
        end else if (grant_sch_s & pf_elig_s) begin
            starve_q <= starve_q + STARVE_W'(1);
        end
    end
`endif

    tx_arbiter_owner_fifo #(
        .MAX_OUT (MAX_OUT)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_s),
        .pop_i   (bus.rx_done),
        .din_i   (owner_q),
        .head_o  (fifo_head_s),
        .empty_o (fifo_empty_s),
        .full_o  (fifo_full_s)
    );

    // Started pulses follow the serializer handshake in the same cycle.
    assign bus.pf_started       = accept_s & (owner_q == OWNER_PF);
    assign bus.sch_started      = accept_s & (owner_q == OWNER_SCH);
    assign bus.tx_command_valid = tx_valid_q;
    assign bus.tx_command       = cmd_q;
    assign bus.rx_for_sch       = fifo_head_s;
    assign bus.reply_err        = reply_err_q;

endmodule
